// File: rtl/arm_idex_operand_stage.sv
// ID/EX operand stage: per-operand forwarding muxes, the ID/EX pipeline
// register, the load-use interlock FSM and a saturating bubble counter.
module arm_idex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              id_valid,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [3:0]        id_rd_num,
  input  logic              id_rd_we,
  input  logic              id_is_load,
  input  logic [DATA_W-1:0] rf_data0,
  input  logic [DATA_W-1:0] rf_data1,
  input  logic [DATA_W-1:0] rf_data2,
  input  logic [1:0]        forward0,
  input  logic [1:0]        forward1,
  input  logic [1:0]        forward2,
  input  logic [2:0]        read_mask,
  input  logic [DATA_W-1:0] ex_fwd_data,
  input  logic [DATA_W-1:0] mem_fwd_data,
  input  logic              ex_stall,
  input  logic              flush,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_op0,
  output logic [DATA_W-1:0] ex_op1,
  output logic [DATA_W-1:0] ex_op2,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [3:0]        ex_rd_num,
  output logic              ex_rd_we,
  output logic              ex_is_load,
  output logic [CNT_W-1:0]  interlock_cnt
);

  typedef enum logic [0:0] {RUN, INTERLOCK} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              hazard;
  logic              ex_dep;
  logic [DATA_W-1:0] op0_sel;
  logic [DATA_W-1:0] op1_sel;
  logic [DATA_W-1:0] op2_sel;

  // Unread operands and the reserved select both fall back to the regfile.
  function automatic logic [DATA_W-1:0] op_mux(
    input logic              used,
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] rf,
    input logic [DATA_W-1:0] exd,
    input logic [DATA_W-1:0] memd
  );
    logic [DATA_W-1:0] r;
    r = rf;
    if (used) begin
      case (sel)
        2'b01:   r = exd;
        2'b10:   r = memd;
        default: r = rf;
      endcase
    end
    return r;
  endfunction

  // Operand selection for the instruction currently in ID.
  always_comb begin
    op0_sel = op_mux(read_mask[0], forward0, rf_data0, ex_fwd_data, mem_fwd_data);
    op1_sel = op_mux(read_mask[1], forward1, rf_data1, ex_fwd_data, mem_fwd_data);
    op2_sel = op_mux(read_mask[2], forward2, rf_data2, ex_fwd_data, mem_fwd_data);
  end

  // Load-use detection, stall output and next-state selection.
  always_comb begin
    ex_dep    = (read_mask[0] && (forward0 == 2'b01)) ||
                (read_mask[1] && (forward1 == 2'b01)) ||
                (read_mask[2] && (forward2 == 2'b01));
    hazard    = (state == RUN) && ex_valid && ex_is_load && id_valid && ex_dep;
    id_stall  = ex_stall || hazard;
    state_nxt = state;
    if (flush)         state_nxt = RUN;
    else if (ex_stall) state_nxt = state;
    else if (hazard)   state_nxt = INTERLOCK;
    else               state_nxt = RUN;
  end

  // Interlock FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_b) state <= RUN;
    else        state <= state_nxt;
  end

  // ID/EX pipeline register and bubble counter: flush > stall > bubble > advance.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      ex_valid      <= 1'b0;
      ex_op0        <= '0;
      ex_op1        <= '0;
      ex_op2        <= '0;
      ex_ctrl       <= '0;
      ex_rd_num     <= '0;
      ex_rd_we      <= 1'b0;
      ex_is_load    <= 1'b0;
      interlock_cnt <= '0;
    end else if (flush) begin
      ex_valid   <= 1'b0;
      ex_rd_we   <= 1'b0;
      ex_is_load <= 1'b0;
    end else if (ex_stall) begin
      ex_valid <= ex_valid;
    end else if (hazard) begin
      ex_valid   <= 1'b0;
      ex_rd_we   <= 1'b0;
      ex_is_load <= 1'b0;
      if (interlock_cnt != '1) interlock_cnt <= interlock_cnt + CNT_W'(1);
    end else begin
      ex_valid   <= id_valid;
      ex_rd_we   <= id_rd_we && id_valid;
      ex_is_load <= id_is_load && id_valid;
      ex_op0     <= op0_sel;
      ex_op1     <= op1_sel;
      ex_op2     <= op2_sel;
      ex_ctrl    <= id_ctrl;
      ex_rd_num  <= id_rd_num;
    end
  end

endmodule

// File: tb/tb_arm_idex_operand_stage.sv
// Directed self-checking bench for arm_idex_operand_stage (CNT_W=2 so
// counter saturation is reachable).
module tb_arm_idex_operand_stage;

  logic        clk;
  logic        rst_b;
  logic        id_valid;
  logic [15:0] id_ctrl;
  logic [3:0]  id_rd_num;
  logic        id_rd_we;
  logic        id_is_load;
  logic [31:0] rf_data0, rf_data1, rf_data2;
  logic [1:0]  forward0, forward1, forward2;
  logic [2:0]  read_mask;
  logic [31:0] ex_fwd_data, mem_fwd_data;
  logic        ex_stall, flush;
  logic        id_stall, ex_valid;
  logic [31:0] ex_op0, ex_op1, ex_op2;
  logic [15:0] ex_ctrl;
  logic [3:0]  ex_rd_num;
  logic        ex_rd_we, ex_is_load;
  logic [1:0]  interlock_cnt;

  int checks   = 0;
  int failures = 0;

  arm_idex_operand_stage #(.DATA_W(32), .CTRL_W(16), .CNT_W(2)) dut (
    .clk(clk), .rst_b(rst_b), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_rd_num(id_rd_num), .id_rd_we(id_rd_we), .id_is_load(id_is_load),
    .rf_data0(rf_data0), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .forward0(forward0), .forward1(forward1), .forward2(forward2),
    .read_mask(read_mask), .ex_fwd_data(ex_fwd_data), .mem_fwd_data(mem_fwd_data),
    .ex_stall(ex_stall), .flush(flush), .id_stall(id_stall), .ex_valid(ex_valid),
    .ex_op0(ex_op0), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_ctrl(ex_ctrl),
    .ex_rd_num(ex_rd_num), .ex_rd_we(ex_rd_we), .ex_is_load(ex_is_load),
    .interlock_cnt(interlock_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst_b = 1'b1; id_valid = 1'b0; id_ctrl = '0; id_rd_num = '0;
    id_rd_we = 1'b0; id_is_load = 1'b0;
    rf_data0 = '0; rf_data1 = '0; rf_data2 = '0;
    forward0 = 2'b00; forward1 = 2'b00; forward2 = 2'b00; read_mask = 3'b000;
    ex_fwd_data = '0; mem_fwd_data = '0; ex_stall = 1'b0; flush = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_b = 1'b0;
    step();
    rst_b = 1'b1;
  endtask

  // Put a valid load writing r5 into EX.
  task automatic push_load();
    idle_inputs();
    id_valid = 1'b1; id_is_load = 1'b1; id_rd_we = 1'b1; id_rd_num = 4'd5;
    step();
  endtask

  // Present an ID instruction that reads the EX result on operand 0.
  task automatic present_consumer();
    idle_inputs();
    id_valid = 1'b1; id_rd_we = 1'b1; id_rd_num = 4'd6;
    forward0 = 2'b01; read_mask = 3'b001; ex_fwd_data = 32'h77; rf_data0 = 32'h99;
  endtask

  task automatic test_reset();
    idle_inputs();
    id_valid = 1'b1; id_rd_we = 1'b1; rf_data0 = 32'hDEAD; id_ctrl = 16'hFFFF;
    rst_b = 1'b0;
    step();
    checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL reset_ex_valid got=%b exp=0", ex_valid); end
    checks++; if (ex_op0 !== 32'h0) begin failures++; $display("FAIL reset_ex_op0 got=%h exp=0", ex_op0); end
    checks++; if (ex_ctrl !== 16'h0) begin failures++; $display("FAIL reset_ex_ctrl got=%h exp=0", ex_ctrl); end
    checks++; if (ex_rd_we !== 1'b0) begin failures++; $display("FAIL reset_ex_rd_we got=%b exp=0", ex_rd_we); end
    checks++; if (interlock_cnt !== 2'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", interlock_cnt); end
    rst_b = 1'b1;
  endtask

  task automatic test_plain_forward();
    do_reset();
    id_valid = 1'b1; id_rd_we = 1'b1; id_rd_num = 4'd3; id_ctrl = 16'h1234;
    forward0 = 2'b01; read_mask = 3'b011; ex_fwd_data = 32'h11; rf_data0 = 32'h22;
    forward1 = 2'b00; rf_data1 = 32'h33;
    forward2 = 2'b10; rf_data2 = 32'h44; mem_fwd_data = 32'h55;
    #1;
    checks++; if (id_stall !== 1'b0) begin failures++; $display("FAIL fwd_id_stall got=%b exp=0", id_stall); end
    step();
    checks++; if (ex_valid !== 1'b1) begin failures++; $display("FAIL fwd_ex_valid got=%b exp=1", ex_valid); end
    checks++; if (ex_op0 !== 32'h11) begin failures++; $display("FAIL fwd_ex_op0 got=%h exp=11", ex_op0); end
    checks++; if (ex_op1 !== 32'h33) begin failures++; $display("FAIL fwd_ex_op1 got=%h exp=33", ex_op1); end
    checks++; if (ex_op2 !== 32'h44) begin failures++; $display("FAIL fwd_ex_op2_unmasked got=%h exp=44", ex_op2); end
    checks++; if (ex_ctrl !== 16'h1234) begin failures++; $display("FAIL fwd_ex_ctrl got=%h exp=1234", ex_ctrl); end
    checks++; if (ex_rd_num !== 4'd3) begin failures++; $display("FAIL fwd_ex_rd_num got=%0d exp=3", ex_rd_num); end
    checks++; if (ex_rd_we !== 1'b1) begin failures++; $display("FAIL fwd_ex_rd_we got=%b exp=1", ex_rd_we); end
    checks++; if (id_stall !== 1'b0) begin failures++; $display("FAIL fwd_id_stall_after got=%b exp=0", id_stall); end
  endtask

  task automatic test_mask_gating();
    do_reset();
    id_valid = 1'b1; rf_data1 = 32'hAA; mem_fwd_data = 32'hBB; ex_fwd_data = 32'hCC;
    forward1 = 2'b10; read_mask = 3'b000;
    step();
    checks++; if (ex_op1 !== 32'hAA) begin failures++; $display("FAIL mask_off_op1 got=%h exp=aa", ex_op1); end
    forward1 = 2'b11; read_mask = 3'b010;
    step();
    checks++; if (ex_op1 !== 32'hAA) begin failures++; $display("FAIL mask_reserved_op1 got=%h exp=aa", ex_op1); end
    forward1 = 2'b10; read_mask = 3'b010;
    step();
    checks++; if (ex_op1 !== 32'hBB) begin failures++; $display("FAIL mask_mem_op1 got=%h exp=bb", ex_op1); end
    forward2 = 2'b01; read_mask = 3'b100; rf_data2 = 32'h12;
    step();
    checks++; if (ex_op2 !== 32'hCC) begin failures++; $display("FAIL mask_ex_op2 got=%h exp=cc", ex_op2); end
  endtask

  task automatic test_load_use();
    do_reset();
    push_load();
    checks++; if (ex_is_load !== 1'b1) begin failures++; $display("FAIL lu_load_in_ex got=%b exp=1", ex_is_load); end
    present_consumer();
    #1;
    checks++; if (id_stall !== 1'b1) begin failures++; $display("FAIL lu_id_stall got=%b exp=1", id_stall); end
    step();
    checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL lu_bubble_valid got=%b exp=0", ex_valid); end
    checks++; if (ex_rd_we !== 1'b0) begin failures++; $display("FAIL lu_bubble_rd_we got=%b exp=0", ex_rd_we); end
    checks++; if (interlock_cnt !== 2'd1) begin failures++; $display("FAIL lu_cnt got=%0d exp=1", interlock_cnt); end
    forward0 = 2'b10; mem_fwd_data = 32'h5A;
    #1;
    checks++; if (id_stall !== 1'b0) begin failures++; $display("FAIL lu_interlock_stall got=%b exp=0", id_stall); end
    step();
    checks++; if (ex_op0 !== 32'h5A) begin failures++; $display("FAIL lu_op0 got=%h exp=5a", ex_op0); end
    checks++; if (ex_valid !== 1'b1) begin failures++; $display("FAIL lu_valid_after got=%b exp=1", ex_valid); end
    checks++; if (interlock_cnt !== 2'd1) begin failures++; $display("FAIL lu_cnt_after got=%0d exp=1", interlock_cnt); end
  endtask

  task automatic test_stall_vs_hazard();
    do_reset();
    push_load();
    present_consumer();
    ex_stall = 1'b1;
    #1;
    checks++; if (id_stall !== 1'b1) begin failures++; $display("FAIL sh_id_stall got=%b exp=1", id_stall); end
    step();
    checks++; if (ex_valid !== 1'b1) begin failures++; $display("FAIL sh_held_valid got=%b exp=1", ex_valid); end
    checks++; if (ex_is_load !== 1'b1) begin failures++; $display("FAIL sh_held_load got=%b exp=1", ex_is_load); end
    checks++; if (ex_rd_num !== 4'd5) begin failures++; $display("FAIL sh_held_rd got=%0d exp=5", ex_rd_num); end
    checks++; if (interlock_cnt !== 2'd0) begin failures++; $display("FAIL sh_cnt_held got=%0d exp=0", interlock_cnt); end
    ex_stall = 1'b0;
    #1;
    checks++; if (id_stall !== 1'b1) begin failures++; $display("FAIL sh_hazard_again got=%b exp=1", id_stall); end
    step();
    checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL sh_bubble got=%b exp=0", ex_valid); end
    checks++; if (interlock_cnt !== 2'd1) begin failures++; $display("FAIL sh_cnt got=%0d exp=1", interlock_cnt); end
    forward0 = 2'b10; mem_fwd_data = 32'h66;
    step();
    checks++; if (ex_valid !== 1'b1) begin failures++; $display("FAIL sh_single_bubble got=%b exp=1", ex_valid); end
    checks++; if (interlock_cnt !== 2'd1) begin failures++; $display("FAIL sh_cnt_final got=%0d exp=1", interlock_cnt); end
  endtask

  task automatic test_flush();
    do_reset();
    push_load();
    present_consumer();
    ex_stall = 1'b1; flush = 1'b1;
    step();
    checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL fl_valid got=%b exp=0", ex_valid); end
    checks++; if (ex_is_load !== 1'b0) begin failures++; $display("FAIL fl_load got=%b exp=0", ex_is_load); end
    checks++; if (ex_rd_we !== 1'b0) begin failures++; $display("FAIL fl_rd_we got=%b exp=0", ex_rd_we); end
    checks++; if (interlock_cnt !== 2'd0) begin failures++; $display("FAIL fl_cnt got=%0d exp=0", interlock_cnt); end
    push_load();
    present_consumer();
    #1;
    checks++; if (id_stall !== 1'b1) begin failures++; $display("FAIL fl_run_hazard got=%b exp=1", id_stall); end
    step();
    checks++; if (interlock_cnt !== 2'd1) begin failures++; $display("FAIL fl_cnt_pre_reset got=%0d exp=1", interlock_cnt); end
    rst_b = 1'b0;
    step();
    rst_b = 1'b1;
    checks++; if (interlock_cnt !== 2'd0) begin failures++; $display("FAIL rst_mid_cnt got=%0d exp=0", interlock_cnt); end
    checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%b exp=0", ex_valid); end
    checks++; if (ex_op0 !== 32'h0) begin failures++; $display("FAIL rst_mid_op0 got=%h exp=0", ex_op0); end
    checks++; if (ex_rd_num !== 4'd0) begin failures++; $display("FAIL rst_mid_rd got=%0d exp=0", ex_rd_num); end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt;
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      exp_cnt = (k >= 3) ? 2'd3 : 2'(k);
      push_load();
      present_consumer();
      step();
      checks++; if (interlock_cnt !== exp_cnt) begin failures++; $display("FAIL sat_cnt_%0d got=%0d exp=%0d", k, interlock_cnt, exp_cnt); end
      forward0 = 2'b10; mem_fwd_data = 32'h1;
      step();
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      idle_inputs();
      id_valid = 1'b1; id_rd_we = 1'b1; rf_data0 = 32'(k * 16'h101); read_mask = 3'b001;
      id_rd_num = 4'(k);
      step();
      checks++; if (ex_op0 !== 32'(k * 16'h101)) begin failures++; $display("FAIL b2b_op0_%0d got=%h exp=%h", k, ex_op0, 32'(k * 16'h101)); end
      checks++; if (ex_rd_num !== 4'(k)) begin failures++; $display("FAIL b2b_rd_%0d got=%0d exp=%0d", k, ex_rd_num, k); end
    end
    idle_inputs();
    id_rd_we = 1'b1; id_is_load = 1'b1;
    step();
    checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL b2b_invalid_slot got=%b exp=0", ex_valid); end
    checks++; if (ex_rd_we !== 1'b0) begin failures++; $display("FAIL b2b_invalid_we got=%b exp=0", ex_rd_we); end
    checks++; if (ex_is_load !== 1'b0) begin failures++; $display("FAIL b2b_invalid_load got=%b exp=0", ex_is_load); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_plain_forward();
    test_mask_gating();
    test_load_use();
    test_stall_vs_hazard();
    test_flush();
    test_saturation();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arm_idex_operand_stage.md
Name: arm_idex_operand_stage

Overview:
ID/EX pipeline stage that consumes the per-operand forwarding selects from the forwarding unit. It muxes each of the three source operands from the register file, the EX result or the MEM result, and latches them with the decoded control bundle into the EX stage. It also owns the load-use interlock (one bubble when EX holds a load whose data is needed), downstream back-pressure, flush, and a saturating interlock-bubble counter.

Parameters:
DATA_W, 32, operand/result width
CTRL_W, 16, width of opaque decoded control bundle passed to EX
CNT_W, 16, width of interlock bubble counter

Ports:
clk  in  1  clock
rst_b  in  1  synchronous active-low reset
id_valid  in  1  ID holds a valid instruction
id_ctrl  in  CTRL_W  decoded control bundle
id_rd_num  in  4  destination register
id_rd_we  in  1  destination write enable
id_is_load  in  1  instruction is a load
rf_data0, rf_data1, rf_data2  in  DATA_W each  register file read data
forward0, forward1, forward2  in  2 each  select: 00 regfile, 01 EX result, 10 MEM result, 11 reserved
read_mask  in  3  bit i set = operand i is really read
ex_fwd_data  in  DATA_W  result currently leaving EX
mem_fwd_data  in  DATA_W  result currently leaving MEM
ex_stall  in  1  EX cannot accept; hold stage
flush  in  1  squash (branch taken / exception)
id_stall  out  1  ID/IF must hold current instruction
ex_valid  out  1  EX stage instruction valid
ex_op0, ex_op1, ex_op2  out  DATA_W each  latched operands
ex_ctrl  out  CTRL_W  latched control
ex_rd_num  out  4  latched destination
ex_rd_we  out  1  latched write enable (forced 0 when bubble)
ex_is_load  out  1  latched load flag
interlock_cnt  out  CNT_W  number of load-use bubbles inserted

Behaviour:
- Reset (rst_b==0 at posedge): all ex_* outputs 0, interlock_cnt 0, FSM RUN. Reset overrides flush and stall.
- Operand mux (comb), per i: if read_mask[i]==0 or forwardi==00 or 11 -> rf_datai; 01 -> ex_fwd_data; 10 -> mem_fwd_data.
- FSM states RUN, INTERLOCK.
- hazard (comb) = state==RUN & ex_valid & ex_is_load & id_valid & OR over i of (read_mask[i] & forwardi==01).
- id_stall (comb) = ex_stall | hazard. Zero-latency path; no register.
- Per-cycle priority at posedge, highest first:
  1. flush: ex_valid<=0, ex_rd_we<=0, ex_is_load<=0, state<=RUN. Applies even when ex_stall=1. Operand/ctrl registers are don't-care.
  2. ex_stall: hold all ex_* registers and state; no bubble; counter unchanged. hazard is re-evaluated next cycle.
  3. hazard: insert bubble (ex_valid<=0, ex_rd_we<=0, ex_is_load<=0), state<=INTERLOCK, interlock_cnt+=1 saturating at all-ones.
  4. otherwise advance: ex_valid<=id_valid, ex_rd_we<=id_rd_we&id_valid, ex_is_load<=id_is_load&id_valid; ex_op*, ex_ctrl, ex_rd_num load from ID/mux; state<=RUN.
- INTERLOCK lasts exactly one advancing cycle. In it, the load has moved to MEM and the forwarding unit now supplies 10. hazard is forced 0 in INTERLOCK, so back-to-back bubbles are impossible for a single load.
- Bubble rule: a bubble always has ex_valid=0 and ex_rd_we=0, so downstream forwarding never matches it.
- id_valid=0 with no hazard: stage advances an invalid slot (ex_valid=0).
- Latency: operand selected in cycle N appears on ex_op* after posedge N (1 cycle).
- Counter saturates; it never wraps.

Test Plan:
- Plain forward: id_valid=1, forward0=01, read_mask=001, ex_fwd_data=0x11, rf_data0=0x22 -> next cycle ex_valid=1, ex_op0=0x11, id_stall=0 throughout.
- Mask gating: forward1=10, read_mask[1]=0, rf_data1=0xAA, mem_fwd_data=0xBB -> ex_op1=0xAA. Same stimulus with forward1=11 and mask set -> ex_op1=0xAA.
- Load-use: EX holds valid load; ID reads it with forward0=01, mask0=1 -> id_stall=1 same cycle, then ex_valid=0, ex_rd_we=0, interlock_cnt=1. Next cycle forward0=10, mem_fwd_data=0x5A -> ex_op0=0x5A, ex_valid=1, id_stall=0.
- Stall vs hazard: ex_stall=1 during the hazard cycle -> ex_* held, cnt unchanged. Release ex_stall -> exactly one bubble, cnt=1.
- Flush priority: flush=1 with ex_stall=1 and hazard active -> ex_valid=0, state RUN, cnt unchanged. Reset mid-INTERLOCK (rst_b=0 one cycle) -> all outputs 0, state RUN.
- Saturation: with CNT_W=2, force 5 load-use hazards -> interlock_cnt reads 3 after the 3rd hazard and stays 3.
